// File: rtl/lm07_reader.sv
// lm07_reader: SPI-style reader for an LM07-class temperature sensor.
// Optional feature: define LM07_READER_AVG_EN to output a running average of the last 4 frames.
`default_nettype none

module lm07_reader #(
    parameter int CLK_DIV = 4,
    parameter int NBITS   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sio,
    output logic             sck,
    output logic             cs_n,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic             busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int         BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    logic [2:0]       state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             phase_q, phase_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             sync1_q, sync2_q;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             load;
    logic             div_end;

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shift_d = shift_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (div_end) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        // Sample on the last clk of the high phase, just before sck falls.
                        shift_d = {shift_q[NBITS-2:0], sync2_q};
                        if (bit_q == BIT_LAST) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (div_end) begin
                    state_d = S_DONE;
                    div_d   = '0;
                    load    = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // sck/cs_n are registered from next state so they leave the block glitch-free.
    assign sck_d  = (state_d == S_SHIFT) && phase_d;
    assign cs_n_d = (state_d == S_IDLE) || (state_d == S_DONE);

`ifdef LM07_READER_AVG_EN
    logic [NBITS-1:0]       hist_q [0:2];
    logic                   first_q;
    logic signed [NBITS+1:0] sum;

    always_comb begin
        if (first_q) begin
            sum = {{2{shift_q[NBITS-1]}}, shift_q} <<< 2;
        end else begin
            sum = $signed({{2{shift_q[NBITS-1]}}, shift_q})
                + $signed({{2{hist_q[0][NBITS-1]}}, hist_q[0]})
                + $signed({{2{hist_q[1][NBITS-1]}}, hist_q[1]})
                + $signed({{2{hist_q[2][NBITS-1]}}, hist_q[2]});
        end
        data_d = sum[NBITS+1:2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q[0] <= '0;
            hist_q[1] <= '0;
            hist_q[2] <= '0;
            first_q   <= 1'b1;
        end else if (load) begin
            hist_q[0] <= shift_q;
            hist_q[1] <= first_q ? shift_q : hist_q[0];
            hist_q[2] <= first_q ? shift_q : hist_q[1];
            first_q   <= 1'b0;
        end
    end
`else
    assign data_d = shift_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            sync1_q <= sio;
            sync2_q <= sync1_q;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            if (load) begin
                data_q <= data_d;
            end
        end
    end

    assign sck   = sck_q;
    assign cs_n  = cs_n_q;
    assign data  = data_q;
    assign valid = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lm07_reader.sv
// Self-checking bench for lm07_reader with a behavioural serial sensor and frame model.
`default_nettype none

module tb_lm07_reader;

    localparam int CLK_DIV = 4;
    localparam int NBITS   = 16;
    localparam int LAT     = 2 * NBITS * CLK_DIV + 2 * CLK_DIV + 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sio   = 1'b0;
    logic              sck;
    logic              cs_n;
    logic [NBITS-1:0]  data;
    logic              valid;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int sck_rises = 0;
    int sck_bad   = 0;
    int cyc       = 0;
    int idx       = 0;
    logic [NBITS-1:0] sensor_word = '0;
    int hist [$];

    lm07_reader #(.CLK_DIV(CLK_DIV), .NBITS(NBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sio   (sio),
        .sck   (sck),
        .cs_n  (cs_n),
        .data  (data),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge sck) sck_rises++;
    always @(sck) if (cs_n === 1'b1 && rst_n === 1'b1) sck_bad++;

    // Sensor: presents MSB when selected, next bit after each falling sck.
    always @(negedge cs_n) begin
        idx = NBITS - 1;
        #1 sio = sensor_word[idx];
    end
    always @(negedge sck) begin
        if (cs_n === 1'b0 && idx > 0) begin
            idx--;
            #1 sio = sensor_word[idx];
        end
    end

    function automatic logic [NBITS-1:0] model_next(input logic [NBITS-1:0] raw);
        int s;
        int v;
        v = $signed(raw);
`ifdef LM07_READER_AVG_EN
        if (hist.size() == 0) begin
            repeat (3) hist.push_back(v);
        end
        hist.push_back(v);
        if (hist.size() > 4) void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        return NBITS'(s >>> 2);
`else
        s = v;
        return NBITS'(s);
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (sck !== 1'b0)   begin n_fail++; $display("FAIL reset_sck got %b want 0", sck); end
        n_checks++; if (cs_n !== 1'b1)  begin n_fail++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (data !== '0)    begin n_fail++; $display("FAIL reset_data got %h want 0", data); end
        rst_n = 1'b1;
        hist.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame(input logic [NBITS-1:0] word);
        int n;
        logic [NBITS-1:0] exp;
        sensor_word = word;
        exp = model_next(word);
        @(negedge clk);
        sck_rises = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n !== LAT) begin n_fail++; $display("FAIL frame_latency word %h got %0d want %0d", word, n, LAT); end
        n_checks++; if (data !== exp) begin n_fail++; $display("FAIL frame_data word %h got %h want %h", word, data, exp); end
        n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL frame_cs_n_at_valid got %b want 1", cs_n); end
        n_checks++; if (sck_rises !== NBITS) begin n_fail++; $display("FAIL frame_sck_rises got %0d want %0d", sck_rises, NBITS); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_after got %b want 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL frame_valid_width got %b want 0", valid); end
        n_checks++; if (data !== exp) begin n_fail++; $display("FAIL frame_data_hold got %h want %h", data, exp); end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 6; k++) begin
            test_frame(NBITS'($urandom));
        end
    endtask

    task automatic test_restart_ignored();
        int nvalid;
        int first;
        logic [NBITS-1:0] exp;
        sensor_word = NBITS'($urandom);
        exp = model_next(sensor_word);
        nvalid = 0;
        first = -1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            start = (n == 10 || n == 60) ? 1'b1 : 1'b0;
            if (valid === 1'b1) begin
                nvalid++;
                if (first < 0) first = n;
                n_checks++; if (data !== exp) begin n_fail++; $display("FAIL restart_data got %h want %h", data, exp); end
            end
        end
        start = 1'b0;
        n_checks++; if (nvalid !== 1) begin n_fail++; $display("FAIL restart_valid_count got %0d want 1", nvalid); end
        n_checks++; if (first !== LAT) begin n_fail++; $display("FAIL restart_latency got %0d want %0d", first, LAT); end
    endtask

    task automatic test_reset_midframe();
        int nvalid;
        sensor_word = NBITS'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_cs_n got %b want 1", cs_n); end
        n_checks++; if (sck !== 1'b0)  begin n_fail++; $display("FAIL midrst_sck got %b want 0", sck); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if (data !== '0)   begin n_fail++; $display("FAIL midrst_data got %h want 0", data); end
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        nvalid = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) nvalid++;
        end
        n_checks++; if (nvalid !== 0) begin n_fail++; $display("FAIL midrst_activity got %0d want 0", nvalid); end
        test_frame(NBITS'($urandom));
    endtask

    task automatic test_back_to_back();
        int t [$];
        int n;
        logic [NBITS-1:0] exp;
        sensor_word = NBITS'($urandom);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (t.size() < 4 && n < 4 * (LAT + 1) + 200) begin
            @(negedge clk);
            n++;
            if (valid === 1'b1) begin
                t.push_back(cyc);
                exp = model_next(sensor_word);
                n_checks++; if (data !== exp) begin n_fail++; $display("FAIL b2b_data got %h want %h", data, exp); end
                if (t.size() == 4) start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++; if (t.size() !== 4) begin n_fail++; $display("FAIL b2b_frames got %0d want 4", t.size()); end
        for (int i = 1; i < t.size(); i++) begin
            n_checks++; if (t[i] - t[i-1] !== LAT + 1) begin n_fail++; $display("FAIL b2b_period got %0d want %0d", t[i] - t[i-1], LAT + 1); end
        end
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_frame(16'h3E80);
        test_frame(16'hFF00);
        test_random_frames();
        test_restart_ignored();
        test_reset_midframe();
        test_back_to_back();
        n_checks++; if (sck_bad !== 0) begin n_fail++; $display("FAIL sck_toggle_while_deselected got %0d want 0", sck_bad); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lm07_reader.md
LM07_READER -- requirements
Module: lm07_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal range 3..255.
REQ-002 SHALL have parameter NBITS, default 16: bits per sensor frame.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request one sensor read; sampled only in IDLE.
REQ-006 SHALL have port sio, input, 1: sensor serial data; asynchronous to clk.
REQ-007 SHALL have port sck, output, 1: serial clock to sensor; idle low.
REQ-008 SHALL have port cs_n, output, 1: sensor chip select, active-low.
REQ-009 SHALL have port data, output, NBITS: last completed reading, two's complement, MSB first on wire.
REQ-010 SHALL have port valid, output, 1: one-cycle pulse when data updates.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL pass sio through a 2-flop synchronizer before use.
REQ-013 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
REQ-014 IDLE: cs_n=1, sck=0; start=1 moves to SETUP next cycle; start=0 stays.
REQ-015 SETUP: cs_n=0, sck=0 for CLK_DIV cycles, then SHIFT.
REQ-016 SHIFT: NBITS SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high; ends with sck low after final high phase.
REQ-017 SHALL shift synchronized sio into the shift register MSB first on the last clk cycle of each SCK high phase.
REQ-018 HOLD: cs_n=0, sck=0 for CLK_DIV cycles, then DONE.
REQ-019 DONE: cs_n=1, data loaded, valid=1 for exactly one cycle, then IDLE.
REQ-020 valid SHALL rise exactly 2*NBITS*CLK_DIV+2*CLK_DIV+1 cycles after the cycle start is sampled in IDLE (137 at defaults).
REQ-021 start while busy=1 SHALL be ignored, neither queued nor aborting the frame.
REQ-022 start high in the DONE cycle SHALL be ignored; start high in the following IDLE cycle SHALL begin a new frame.
REQ-023 data SHALL hold its value between valid pulses.
REQ-024 Exactly NBITS rising edges of sck SHALL occur per frame; sck SHALL never toggle while cs_n=1.

Reset
REQ-025 rst_n low SHALL immediately force FSM=IDLE, sck=0, cs_n=1, valid=0, busy=0, data=0, and clear the shift register, synchronizer, bit counter, divider counter and averaging history.
REQ-026 Reset mid-frame SHALL abort the frame with no valid pulse; after rst_n rises the block SHALL wait for a fresh start.
REQ-027 When reset and start are both asserted, reset SHALL win.

Configuration
REQ-028 Macro LM07_READER_AVG_EN SHALL select averaging.
REQ-029 Without the macro, data SHALL be the raw frame.
REQ-030 With the macro, data SHALL be the arithmetic-shift-right-by-2 of the 18-bit signed sum of the last 4 raw frames, truncated to NBITS.
REQ-031 With the macro, the first frame after reset SHALL preload all 4 history entries with that frame.
REQ-032 With the macro, latency, valid timing and interface SHALL be unchanged.

Verification
REQ-033 Sensor model drives 0x3E80, CLK_DIV=4, start pulse -> 16 sck rises, valid at cycle 137, data=0x3E80, cs_n high at valid.
REQ-034 Sensor model drives 0xFF00 -> data=0xFF00 and busy low the cycle after valid.
REQ-035 start re-pulsed at cycles 10 and 60 of a frame -> single frame, single valid at cycle 137.
REQ-036 rst_n low at cycle 40 of a frame -> same-instant cs_n=1, sck=0, busy=0, data=0; no valid during the following 200 cycles without start.
REQ-037 With LM07_READER_AVG_EN, frames 0x0100, 0x0200, 0x0300, 0x0400 -> data 0x0100, 0x0140, 0x01C0, 0x0280.
REQ-038 Back-to-back: start held high continuously -> frames repeat every 138 cycles, one valid each, sck low in all gaps.
